// File: rtl/sine_cos_pkg.sv
// Shared types and constants for the sine/cos burst sequencer.
// Holds the FSM state encoding, oscillator width and default widths.
package sine_cos_pkg;

    localparam int OSC_W     = 8;
    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Sign of a two's complement oscillator sample.
    function automatic logic is_negative(input logic [OSC_W-1:0] v);
        logic signed [OSC_W-1:0] zero_v;
        zero_v = '0;
        return ($signed(v) < zero_v);
    endfunction

    function automatic logic is_active(input state_e s);
        return (s == ST_PRIME) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sine_cos_burst_ctrl_if.sv
// Register/control side of the burst sequencer: configuration, start/stop
// requests and status returned to the controller.
interface sine_cos_burst_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
);
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_cycles;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output cfg_div, cfg_cycles, start, stop,
        input  busy, done, cycle_cnt
    );

    modport slave (
        input  cfg_div, cfg_cycles, start, stop,
        output busy, done, cycle_cnt
    );
endinterface

// File: rtl/sine_cos_step_div.sv
// Step divider: counts 0..term and emits a tick on the terminal count while
// enabled. The terminal value is captured with load and held for the burst.
module sine_cos_step_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] term_r;
    logic             at_term_s;

    assign at_term_s = (cnt_r == term_r);
    assign tick      = enable && at_term_s;

    // Divider counter and terminal-count shadow register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= '0;
            term_r <= '0;
        end else begin
            if (clear) begin
                cnt_r <= '0;
            end else if (enable) begin
                cnt_r <= at_term_s ? '0 : (cnt_r + DIV_W'(1));
            end else begin
                cnt_r <= cnt_r;
            end
            if (load) begin
                term_r <= load_val;
            end else begin
                term_r <= term_r;
            end
        end
    end

endmodule

// File: rtl/sine_cos_burst_ctrl.sv
// Burst sequencer for the 8-bit sine/cos oscillator: primes it, paces its step
// enable, counts upward sine zero crossings and ends bursts on a period boundary.
module sine_cos_burst_ctrl
    import sine_cos_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    sine_cos_burst_ctrl_if.slave    ctrl,
    input  logic [OSC_W-1:0]        osc_sine,
    output logic                    osc_en,
    output logic                    osc_rst_n,
    output logic                    sample_valid
);

    state_e           state_r;
    state_e           state_nx_s;
    logic [CNT_W-1:0] shadow_cycles_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             prev_neg_r;
    logic             sample_valid_r;
    logic             osc_rst_n_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             running_s;
    logic             sine_neg_s;
    logic             crossing_s;
    logic             term_hit_s;
    logic             tick_s;

    assign accept_s   = (state_r == ST_IDLE) && ctrl.start;
    assign running_s  = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign sine_neg_s = is_negative(osc_sine);
    assign crossing_s = running_s && sample_valid_r && prev_neg_r && !sine_neg_s;
    assign cnt_inc_s  = cycle_cnt_r + CNT_W'(1);
    // Zero cycle count means continuous mode, so it never terminates on count.
    assign term_hit_s = crossing_s && (shadow_cycles_r != '0) && (cnt_inc_s == shadow_cycles_r);

    sine_cos_step_div #(.DIV_W(DIV_W)) u_step_div (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept_s),
        .enable   (running_s),
        .load     (accept_s),
        .load_val (ctrl.cfg_div),
        .tick     (tick_s)
    );

    assign osc_en         = tick_s;
    assign osc_rst_n      = osc_rst_n_r;
    assign sample_valid   = sample_valid_r;
    assign ctrl.busy      = busy_r;
    assign ctrl.done      = done_r;
    assign ctrl.cycle_cnt = cycle_cnt_r;

    // Next-state logic; a terminating crossing takes priority over stop.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (ctrl.start) state_nx_s = ST_PRIME; else state_nx_s = ST_IDLE;
            ST_PRIME: if (ctrl.stop)  state_nx_s = ST_DRAIN; else state_nx_s = ST_RUN;
            ST_RUN: begin
                if (term_hit_s) begin
                    state_nx_s = ST_DONE;
                end else if (ctrl.stop) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: if (crossing_s) state_nx_s = ST_DONE; else state_nx_s = ST_DRAIN;
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            osc_rst_n_r    <= 1'b0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            osc_rst_n_r    <= !accept_s;
            sample_valid_r <= tick_s;
            busy_r         <= is_active(state_nx_s);
            done_r         <= (state_nx_s == ST_DONE);
        end
    end

    // Burst shadow config, sign history and completed-period counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_cycles_r <= '0;
            cycle_cnt_r     <= '0;
            prev_neg_r      <= 1'b0;
        end else if (accept_s) begin
            shadow_cycles_r <= ctrl.cfg_cycles;
            cycle_cnt_r     <= '0;
            prev_neg_r      <= 1'b0;
        end else begin
            shadow_cycles_r <= shadow_cycles_r;
            cycle_cnt_r     <= crossing_s ? cnt_inc_s : cycle_cnt_r;
            prev_neg_r      <= (running_s && sample_valid_r) ? sine_neg_s : prev_neg_r;
        end
    end

endmodule

// File: tb/tb_sine_cos_burst_ctrl.sv
// Directed bench for sine_cos_burst_ctrl with an 8-phase behavioural oscillator.
// Cycle numbers count from the cycle in which start is presented (cycle 0).
module tb_sine_cos_burst_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] osc_sine;
    logic       osc_en;
    logic       osc_rst_n;
    logic       sample_valid;
    logic [2:0] phase;
    int         n_cmp;
    int         n_err;

    sine_cos_burst_ctrl_if #(.DIV_W(16), .CNT_W(8)) ctrl_if ();

    sine_cos_burst_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl         (ctrl_if),
        .osc_sine     (osc_sine),
        .osc_en       (osc_en),
        .osc_rst_n    (osc_rst_n),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator: sine at 45-degree steps, phase 0 after reset; 5..7 are negative.
    always @(posedge clk) begin
        if (!osc_rst_n) phase <= 3'd0;
        else if (osc_en) phase <= phase + 3'd1;
    end

    always_comb begin
        case (phase)
            3'd0: osc_sine = 8'd0;
            3'd1: osc_sine = 8'd90;
            3'd2: osc_sine = 8'd127;
            3'd3: osc_sine = 8'd90;
            3'd4: osc_sine = 8'd0;
            3'd5: osc_sine = 8'hA6;
            3'd6: osc_sine = 8'h81;
            3'd7: osc_sine = 8'hA6;
            default: osc_sine = 8'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (osc_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_osc_rst_n: got %0b expected 0", osc_rst_n); end
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        n_cmp++; if (osc_rst_n !== 1'b1) begin n_err++; $display("FAIL idle_osc_rst_n: got %0b expected 1", osc_rst_n); end
        n_cmp++; if (osc_en !== 1'b0) begin n_err++; $display("FAIL idle_osc_en: got %0b expected 0", osc_en); end
        n_cmp++; if (ctrl_if.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0b expected 0", ctrl_if.busy); end
        n_cmp++; if (ctrl_if.done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %0b expected 0", ctrl_if.done); end
        n_cmp++; if (ctrl_if.cycle_cnt !== 8'd0) begin n_err++; $display("FAIL idle_cnt: got %0d expected 0", ctrl_if.cycle_cnt); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL idle_sv: got %0b expected 0", sample_valid); end
    endtask

    // div=3, cycles=2: steps at cycles 5,9,..; crossings seen at 34 and 66; done at 67.
    task automatic test_basic_burst();
        int  cyc;
        logic exp_en;
        logic prev_en;
        ctrl_if.cfg_div = 16'd3; ctrl_if.cfg_cycles = 8'd2; ctrl_if.start = 1'b1;
        cyc = 0;
        tick(); cyc = 1; ctrl_if.start = 1'b0;
        n_cmp++; if (osc_rst_n !== 1'b0) begin n_err++; $display("FAIL prime_osc_rst_n: got %0b expected 0", osc_rst_n); end
        n_cmp++; if (ctrl_if.busy !== 1'b1) begin n_err++; $display("FAIL prime_busy: got %0b expected 1", ctrl_if.busy); end
        n_cmp++; if (osc_en !== 1'b0) begin n_err++; $display("FAIL prime_osc_en: got %0b expected 0", osc_en); end
        prev_en = 1'b0;
        while (ctrl_if.done !== 1'b1 && cyc < 200) begin
            tick(); cyc++;
            if (cyc == 2) begin
                n_cmp++; if (osc_rst_n !== 1'b1) begin n_err++; $display("FAIL run_osc_rst_n: got %0b expected 1", osc_rst_n); end
            end
            if (ctrl_if.done !== 1'b1) begin
                exp_en = (cyc >= 2) && ((cyc - 2) % 4 == 3);
                n_cmp++; if (osc_en !== exp_en) begin n_err++; $display("FAIL basic_en@%0d: got %0b expected %0b", cyc, osc_en, exp_en); end
                n_cmp++; if (sample_valid !== prev_en) begin n_err++; $display("FAIL basic_sv@%0d: got %0b expected %0b", cyc, sample_valid, prev_en); end
                prev_en = exp_en;
            end
        end
        n_cmp++; if (cyc != 67) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected 67", cyc); end
        n_cmp++; if (ctrl_if.cycle_cnt !== 8'd2) begin n_err++; $display("FAIL basic_cnt: got %0d expected 2", ctrl_if.cycle_cnt); end
        n_cmp++; if (ctrl_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %0b expected 0", ctrl_if.busy); end
        n_cmp++; if (osc_en !== 1'b0) begin n_err++; $display("FAIL basic_en_at_done: got %0b expected 0", osc_en); end
        // start presented during DONE must be dropped
        ctrl_if.cfg_div = 16'd0; ctrl_if.start = 1'b1;
        tick(); ctrl_if.start = 1'b0;
        n_cmp++; if (ctrl_if.done !== 1'b0) begin n_err++; $display("FAIL done_width: got %0b expected 0", ctrl_if.done); end
        n_cmp++; if (ctrl_if.busy !== 1'b0) begin n_err++; $display("FAIL start_in_done_busy: got %0b expected 0", ctrl_if.busy); end
        n_cmp++; if (osc_rst_n !== 1'b1) begin n_err++; $display("FAIL start_in_done_prime: got %0b expected 1", osc_rst_n); end
        tick();
        n_cmp++; if (ctrl_if.busy !== 1'b0) begin n_err++; $display("FAIL start_in_done_busy2: got %0b expected 0", ctrl_if.busy); end
        n_cmp++; if (ctrl_if.cycle_cnt !== 8'd2) begin n_err++; $display("FAIL cnt_hold: got %0d expected 2", ctrl_if.cycle_cnt); end
    endtask

    // div=0 continuous: crossings at 10,18; stop at 20 -> DRAIN; crossing at 26; done at 27.
    task automatic test_stop_drain();
        int cyc;
        ctrl_if.cfg_div = 16'd0; ctrl_if.cfg_cycles = 8'd0; ctrl_if.start = 1'b1;
        cyc = 0;
        tick(); cyc = 1; ctrl_if.start = 1'b0;
        while (cyc < 20) begin tick(); cyc++; end
        chk("cont_cnt_before_stop", 32'(ctrl_if.cycle_cnt), 32'd2);
        ctrl_if.stop = 1'b1;
        tick(); cyc++; ctrl_if.stop = 1'b0;
        chk("drain_busy", 32'(ctrl_if.busy), 32'd1);
        chk("drain_no_done", 32'(ctrl_if.done), 32'd0);
        while (cyc < 26) begin tick(); cyc++; end
        chk("drain_en_before_done", 32'(osc_en), 32'd1);
        chk("drain_cross_sv", 32'(sample_valid), 32'd1);
        while (ctrl_if.done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        chk("drain_done_cycle", 32'(cyc), 32'd27);
        chk("drain_cnt", 32'(ctrl_if.cycle_cnt), 32'd3);
        chk("drain_en_at_done", 32'(osc_en), 32'd0);
        tick();
    endtask

    // div=1, cycles=1: steps on odd cycles from 3; start with div=5 at cycle 6 is ignored.
    task automatic test_start_while_busy();
        int   cyc;
        logic exp_en;
        ctrl_if.cfg_div = 16'd1; ctrl_if.cfg_cycles = 8'd1; ctrl_if.start = 1'b1;
        cyc = 0;
        tick(); cyc = 1; ctrl_if.start = 1'b0;
        while (ctrl_if.done !== 1'b1 && cyc < 100) begin
            if (cyc == 6) begin
                ctrl_if.cfg_div = 16'd5; ctrl_if.cfg_cycles = 8'd9; ctrl_if.start = 1'b1;
            end
            tick(); cyc++;
            ctrl_if.start = 1'b0;
            if (ctrl_if.done !== 1'b1) begin
                exp_en = (cyc >= 3) && (cyc % 2 == 1);
                n_cmp++; if (osc_en !== exp_en) begin n_err++; $display("FAIL busy_start_en@%0d: got %0b expected %0b", cyc, osc_en, exp_en); end
            end
        end
        n_cmp++; if (cyc != 19) begin n_err++; $display("FAIL busy_start_done_cycle: got %0d expected 19", cyc); end
        n_cmp++; if (ctrl_if.cycle_cnt !== 8'd1) begin n_err++; $display("FAIL busy_start_cnt: got %0d expected 1", ctrl_if.cycle_cnt); end
        tick();
    endtask

    // div=0, cycles=1: terminating crossing at cycle 10 with stop in the same cycle.
    task automatic test_stop_coincident();
        int cyc;
        int n_done;
        ctrl_if.cfg_div = 16'd0; ctrl_if.cfg_cycles = 8'd1; ctrl_if.start = 1'b1;
        cyc = 0;
        tick(); cyc = 1; ctrl_if.start = 1'b0;
        while (cyc < 10) begin tick(); cyc++; end
        chk("coinc_sv", 32'(sample_valid), 32'd1);
        ctrl_if.stop = 1'b1;
        tick(); ctrl_if.stop = 1'b0;
        chk("coinc_done", 32'(ctrl_if.done), 32'd1);
        chk("coinc_cnt", 32'(ctrl_if.cycle_cnt), 32'd1);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ctrl_if.done === 1'b1) n_done++;
        end
        chk("coinc_extra_done", 32'(n_done), 32'd0);
        chk("coinc_busy_after", 32'(ctrl_if.busy), 32'd0);
        chk("coinc_cnt_hold", 32'(ctrl_if.cycle_cnt), 32'd1);
    endtask

    // Reset at cycle 42 of a div=3 continuous burst, then a normal div=0/cycles=1 burst.
    task automatic test_reset_mid_run();
        int cyc;
        int n_done;
        ctrl_if.cfg_div = 16'd3; ctrl_if.cfg_cycles = 8'd0; ctrl_if.start = 1'b1;
        cyc = 0;
        tick(); cyc = 1; ctrl_if.start = 1'b0;
        while (cyc < 42) begin tick(); cyc++; end
        chk("mid_cnt", 32'(ctrl_if.cycle_cnt), 32'd1);
        chk("mid_sv", 32'(sample_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_osc_rst_n", 32'(osc_rst_n), 32'd0);
        chk("mid_rst_sv", 32'(sample_valid), 32'd0);
        chk("mid_rst_busy", 32'(ctrl_if.busy), 32'd0);
        chk("mid_rst_done", 32'(ctrl_if.done), 32'd0);
        chk("mid_rst_cnt", 32'(ctrl_if.cycle_cnt), 32'd0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ctrl_if.done === 1'b1 || osc_en === 1'b1) n_done++;
        end
        chk("mid_rst_quiet", 32'(n_done), 32'd0);
        reset = 1'b1;
        tick(); tick();
        ctrl_if.cfg_div = 16'd0; ctrl_if.cfg_cycles = 8'd1; ctrl_if.start = 1'b1;
        cyc = 0;
        tick(); cyc = 1; ctrl_if.start = 1'b0;
        while (ctrl_if.done !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        chk("post_rst_done_cycle", 32'(cyc), 32'd11);
        chk("post_rst_cnt", 32'(ctrl_if.cycle_cnt), 32'd1);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ctrl_if.cfg_div = 16'd0;
        ctrl_if.cfg_cycles = 8'd0;
        ctrl_if.start = 1'b0;
        ctrl_if.stop = 1'b0;
        test_reset();
        test_basic_burst();
        test_stop_drain();
        test_start_while_busy();
        test_stop_coincident();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
